// File: rtl/calc_data_bus_responder.sv
// rtl/calc_data_bus_responder.sv - data-memory responder: word RAM, keypad FIFO, display, cycle counter
// Optional CYCLES register at 0x40C is built only when CALC_CYCLE_COUNTER_EN is defined.
module calc_data_bus_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Unmapped,
  input  logic        KeyValid,
  input  logic [7:0]  KeyData,
  output logic        KeyReady,
  output logic [31:0] Display
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int RIW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   display_q, display_d;

  logic          is_ram, is_mmio, is_cyc;
  logic [1:0]    reg_sel;
  logic [RIW-1:0] ram_idx;
  logic          full, empty, push, pop;
  logic [4:0]    count5;

  assign is_ram  = (Addr[31:10] == 22'd0) && (32'(Addr[9:2]) < RAM_WORDS);
  assign is_mmio = (Addr[31:4] == 28'h0000040);
  assign reg_sel = Addr[3:2];
  assign ram_idx = Addr[RIW+1:2];
`ifdef CALC_CYCLE_COUNTER_EN
  assign is_cyc  = 1'b1;
`else
  assign is_cyc  = 1'b0;
`endif

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign KeyReady = !full;
  assign push     = KeyValid && !full;
  assign pop      = is_mmio && (reg_sel == 2'd0) && MemRead && !empty;
  assign count5   = 5'(count_q);
  assign Display  = display_q;

`ifdef CALC_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;
  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (is_mmio && reg_sel == 2'd3 && MemWrite) cycles_d = 32'd0;
  end
  always_ff @(posedge CLK) begin
    if (RST) cycles_q <= 32'd0;
    else     cycles_q <= cycles_d;
  end
`endif

  always_comb begin
    ReadData = 32'd0;
    Unmapped = 1'b0;
    if (is_ram) begin
      ReadData = ram_q[ram_idx];
    end else if (is_mmio && (reg_sel != 2'd3 || is_cyc)) begin
      case (reg_sel)
        2'd0:    ReadData = empty ? 32'd0 : {24'd0, fifo_q[rd_ptr_q]};
        2'd1:    ReadData = {23'd0, count5, 1'b0, ovf_q, full, !empty};
        2'd2:    ReadData = display_q;
`ifdef CALC_CYCLE_COUNTER_EN
        default: ReadData = cycles_q;
`else
        default: ReadData = 32'd0;
`endif
      endcase
    end else begin
      Unmapped = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    ovf_d     = ovf_q;
    // A same-cycle overflow beats a software clear.
    if (is_mmio && reg_sel == 2'd1 && MemWrite && WriteData[2]) ovf_d = 1'b0;
    if (KeyValid && full) ovf_d = 1'b1;
    display_d = (is_mmio && reg_sel == 2'd2 && MemWrite) ? WriteData : display_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      display_q <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      display_q <= display_d;
    end
  end

  // Storage arrays carry no reset; stale FIFO slots are never visible once count is 0.
  always_ff @(posedge CLK) begin
    if (!RST && push) fifo_q[wr_ptr_q] <= KeyData;
    if (!RST && is_ram && MemWrite) ram_q[ram_idx] <= WriteData;
  end
endmodule

// File: tb/tb_calc_data_bus_responder.sv
// tb/tb_calc_data_bus_responder.sv - directed self-checking bench for calc_data_bus_responder
module tb_calc_data_bus_responder;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic        Unmapped;
  logic        KeyValid = 1'b0;
  logic [7:0]  KeyData = 8'd0;
  logic        KeyReady;
  logic [31:0] Display;

  int n_checks = 0;
  int n_fail   = 0;

  calc_data_bus_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .Addr(Addr), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
    .Unmapped(Unmapped), .KeyValid(KeyValid), .KeyData(KeyData),
    .KeyReady(KeyReady), .Display(Display)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] k);
    KeyValid = 1'b1; KeyData = k;
    tick();
    KeyValid = 1'b0;
  endtask

  task automatic read_at(input logic [31:0] a);
    Addr = a;
    #1;
  endtask

  task automatic test_reset();
    write_word(32'h408, 32'h1234);
    do_reset();
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h exp %h", ReadData, 32'h0); end
    n_checks++; if (Unmapped !== 1'b0) begin n_fail++; $display("FAIL reset_status_mapped got %b exp 0", Unmapped); end
    read_at(32'h408);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_display_rd got %h exp %h", ReadData, 32'h0); end
    n_checks++; if (Display !== 32'h0) begin n_fail++; $display("FAIL reset_display got %h exp %h", Display, 32'h0); end
    n_checks++; if (KeyReady !== 1'b1) begin n_fail++; $display("FAIL reset_keyready got %b exp 1", KeyReady); end
  endtask

  task automatic test_ram();
    write_word(32'h010, 32'hDEADBEEF);
    read_at(32'h010);
    n_checks++; if (ReadData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd010 got %h exp %h", ReadData, 32'hDEADBEEF); end
    read_at(32'h013);
    n_checks++; if (ReadData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd013 got %h exp %h", ReadData, 32'hDEADBEEF); end
    read_at(32'h500);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got %h exp 0", ReadData); end
    n_checks++; if (Unmapped !== 1'b1) begin n_fail++; $display("FAIL unmapped_flag got %b exp 1", Unmapped); end
    // Same-cycle write shows old data until the edge.
    Addr = 32'h010; WriteData = 32'h12345678; MemWrite = 1'b1;
    #1;
    n_checks++; if (ReadData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_old_data got %h exp %h", ReadData, 32'hDEADBEEF); end
    tick();
    MemWrite = 1'b0;
    n_checks++; if (ReadData !== 32'h12345678) begin n_fail++; $display("FAIL ram_new_data got %h exp %h", ReadData, 32'h12345678); end
    write_word(32'h0FC, 32'hCAFEF00D);
    read_at(32'h0FC);
    n_checks++; if (ReadData !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ram_last_word got %h exp %h", ReadData, 32'hCAFEF00D); end
    read_at(32'h100);
    n_checks++; if (Unmapped !== 1'b1) begin n_fail++; $display("FAIL ram_beyond got %b exp 1", Unmapped); end
  endtask

  task automatic test_fifo_basic();
    do_reset();
    push_key(8'h31); push_key(8'h32); push_key(8'h33);
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h031) begin n_fail++; $display("FAIL fifo3_status got %h exp %h", ReadData, 32'h031); end
    Addr = 32'h400; MemRead = 1'b1;
    #1;
    n_checks++; if (ReadData !== 32'h31) begin n_fail++; $display("FAIL pop1 got %h exp %h", ReadData, 32'h31); end
    tick();
    n_checks++; if (ReadData !== 32'h32) begin n_fail++; $display("FAIL pop2 got %h exp %h", ReadData, 32'h32); end
    tick();
    MemRead = 1'b0;
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h011) begin n_fail++; $display("FAIL fifo1_status got %h exp %h", ReadData, 32'h011); end
    read_at(32'h400);
    n_checks++; if (ReadData !== 32'h33) begin n_fail++; $display("FAIL fifo_head got %h exp %h", ReadData, 32'h33); end
    MemRead = 1'b1;
    tick(); tick();
    MemRead = 1'b0;
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL empty_rd got %h exp 0", ReadData); end
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL empty_status got %h exp 0", ReadData); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push_key(8'h40 + 8'(i));
      if (i == 7) begin
        n_checks++; if (KeyReady !== 1'b0) begin n_fail++; $display("FAIL full_keyready got %b exp 0", KeyReady); end
      end
    end
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h087) begin n_fail++; $display("FAIL full_status got %h exp %h", ReadData, 32'h087); end
    write_word(32'h404, 32'h4);
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h083) begin n_fail++; $display("FAIL ovf_clear got %h exp %h", ReadData, 32'h083); end
    // Overflow set and clear at the same edge: set wins.
    KeyValid = 1'b1; KeyData = 8'hEE;
    write_word(32'h404, 32'h4);
    KeyValid = 1'b0;
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h087) begin n_fail++; $display("FAIL ovf_set_wins got %h exp %h", ReadData, 32'h087); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_k;
    Addr = 32'h400; MemRead = 1'b1; KeyValid = 1'b1; KeyData = 8'h55;
    #1;
    n_checks++; if (ReadData !== 32'h40) begin n_fail++; $display("FAIL fullpop_data got %h exp %h", ReadData, 32'h40); end
    n_checks++; if (KeyReady !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready got %b exp 0", KeyReady); end
    tick();
    MemRead = 1'b0;
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h075) begin n_fail++; $display("FAIL fullpop_status got %h exp %h", ReadData, 32'h075); end
    tick();
    KeyValid = 1'b0;
    #1;
    n_checks++; if (ReadData !== 32'h087) begin n_fail++; $display("FAIL refill_status got %h exp %h", ReadData, 32'h087); end
    Addr = 32'h400; MemRead = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_k = (i == 7) ? 8'h55 : 8'h41 + 8'(i);
      #1;
      n_checks++; if (ReadData !== {24'd0, exp_k}) begin n_fail++; $display("FAIL drain_%0d got %h exp %h", i, ReadData, exp_k); end
      tick();
    end
    MemRead = 1'b0;
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h004) begin n_fail++; $display("FAIL drained_status got %h exp %h", ReadData, 32'h004); end
  endtask

  task automatic test_display();
    write_word(32'h408, 32'hA5A5_0F0F);
    n_checks++; if (Display !== 32'hA5A50F0F) begin n_fail++; $display("FAIL display_out got %h exp %h", Display, 32'hA5A50F0F); end
    read_at(32'h408);
    n_checks++; if (ReadData !== 32'hA5A50F0F) begin n_fail++; $display("FAIL display_rd got %h exp %h", ReadData, 32'hA5A50F0F); end
    write_word(32'h600, 32'h1);
    n_checks++; if (Display !== 32'hA5A50F0F) begin n_fail++; $display("FAIL unmapped_wr got %h exp %h", Display, 32'hA5A50F0F); end
    RST = 1'b1; KeyValid = 1'b1; KeyData = 8'h77;
    write_word(32'h408, 32'h1111);
    RST = 1'b0; KeyValid = 1'b0;
    n_checks++; if (Display !== 32'h0) begin n_fail++; $display("FAIL rst_over_wr got %h exp 0", Display); end
    read_at(32'h404);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL rst_over_push got %h exp 0", ReadData); end
  endtask

  task automatic test_cycles();
`ifdef CALC_CYCLE_COUNTER_EN
    write_word(32'h40C, 32'h0);
    repeat (5) tick();
    read_at(32'h40C);
    n_checks++; if (ReadData !== 32'd5) begin n_fail++; $display("FAIL cycles_5 got %h exp 5", ReadData); end
    n_checks++; if (Unmapped !== 1'b0) begin n_fail++; $display("FAIL cycles_mapped got %b exp 0", Unmapped); end
    force dut.cycles_q = 32'hFFFFFFFF;
    #1;
    release dut.cycles_q;
    #1;
    n_checks++; if (ReadData !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL cycles_pre got %h exp ffffffff", ReadData); end
    tick();
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL cycles_wrap got %h exp 0", ReadData); end
`else
    write_word(32'h40C, 32'h5);
    repeat (3) tick();
    read_at(32'h40C);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL nocyc_rd got %h exp 0", ReadData); end
    n_checks++; if (Unmapped !== 1'b1) begin n_fail++; $display("FAIL nocyc_unmapped got %b exp 1", Unmapped); end
`endif
  endtask

  initial begin
    tick();
    test_reset();
    test_ram();
    test_fifo_basic();
    test_fifo_full();
    test_full_pop_push();
    test_display();
    test_cycles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
